// File: rtl/i2s_rx_deser_pkg.sv
// i2s_rx_deser shared types
// FSM state encoding and channel codes
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_deser_edge.sv
// edge_rise_det: registered rising-edge detector
// rise is high in the first clk cycle a level is seen high
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  // remember last sampled level
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S serial-to-parallel receiver
// bck is sampled as data; all state advances on its rise
module i2s_rx_deser
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_MIN     = 16,
  parameter int SLOT_MAX     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bck,
  input  logic                    lrck,
  input  logic                    sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_channel,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int CW = $clog2(SLOT_MAX + 1);

  state_t                  state;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-2:0] shift_reg;
  logic                    lrck_prev;
  logic                    chan;
  logic                    rise;

  logic                    change;
  logic                    complete;
  logic                    slot_bad;
  logic [SAMPLE_WIDTH-1:0] word;

  edge_rise_det u_bck_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bck),
    .rise  (rise)
  );

  // slot-boundary and word-completion decode for this edge
  always_comb begin
    change   = lrck ^ lrck_prev;
    complete = (state == ST_SHIFT) &&
               (bit_cnt == CW'(SAMPLE_WIDTH));
    word     = {shift_reg, sdata};
    slot_bad = (state == ST_DELAY) ||
               ((state == ST_SHIFT) && !complete) ||
               ((state != ST_HUNT) &&
                (bit_cnt < CW'(SLOT_MIN)));
  end

  // stream FSM, shifter, counter and output holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_HUNT;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      lrck_prev      <= 1'b0;
      chan           <= CH_LEFT;
      sample_data    <= '0;
      sample_channel <= CH_LEFT;
      sample_valid   <= 1'b0;
      overflow       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (sample_valid && sample_ready)
        sample_valid <= 1'b0;
      if (rise) begin
        lrck_prev <= lrck;
        unique case (state)
          ST_HUNT: ;
          ST_DELAY: begin
            state   <= ST_SHIFT;
            bit_cnt <= CW'(1);
          end
          ST_SHIFT: begin
            shift_reg <= word[SAMPLE_WIDTH-2:0];
            bit_cnt   <= bit_cnt + 1'b1;
            if (complete) state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (bit_cnt != CW'(SLOT_MAX))
              bit_cnt <= bit_cnt + 1'b1;
          end
          default: state <= ST_HUNT;
        endcase
        if (complete) begin
          if (!sample_valid || sample_ready) begin
            sample_data    <= word;
            sample_channel <= chan;
            sample_valid   <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        // a word-select change always opens a fresh slot
        if (change) begin
          state   <= ST_DELAY;
          bit_cnt <= '0;
          chan    <= lrck;
          if (slot_bad) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed + random bench
// slot-level reference model checked every clk
module tb_i2s_rx_deser;

  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          bck;
  logic          lrck;
  logic          sdata;
  logic [SW-1:0] sample_data;
  logic          sample_channel;
  logic          sample_valid;
  logic          sample_ready;
  logic          overflow;
  logic          frame_err;

  i2s_rx_deser dut (
    .clk            (clk),
    .reset          (reset),
    .bck            (bck),
    .lrck           (lrck),
    .sdata          (sdata),
    .sample_data    (sample_data),
    .sample_channel (sample_channel),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .overflow       (overflow),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_seen = 0;
  bit rand_rdy = 0;
  bit carry_v = 0;
  logic carry_b = 1'b0;

  // reference model state: rise index, index of last lrck change
  bit            m_bprev, m_lprev, m_have;
  int            m_i, m_c;
  logic [SW-1:0] m_word;
  logic          m_ch;
  logic          hv, hc, ov, fe;
  logic [SW-1:0] hd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit            ld;
    bit            acc;
    logic [SW-1:0] nw;
    logic          nc;
    ld = 0; nw = '0; nc = 1'b0;
    if (reset) begin
      m_bprev = 0; m_lprev = 0; m_have = 0;
      m_i = 0; m_c = 0; m_word = '0; m_ch = 0;
      hv = 0; hc = 0; ov = 0; fe = 0; hd = '0;
    end else begin
      fe = 0;
      acc = hv && sample_ready;
      if (bck && !m_bprev) begin
        m_i++;
        if (m_have && m_i >= m_c + 2 && m_i <= m_c + SW + 1)
          m_word = {m_word[SW-2:0], sdata};
        if (m_have && m_i == m_c + SW + 1) begin
          ld = 1; nw = m_word; nc = m_ch;
        end
        if (lrck != m_lprev) begin
          if (m_have && m_i < m_c + SW + 1) fe = 1;
          m_have = 1; m_c = m_i; m_ch = lrck;
        end
        m_lprev = lrck;
      end
      m_bprev = bck;
      if (ld) begin
        if (!hv || acc) begin
          hd = nw; hc = nc; hv = 1;
        end else ov = 1;
      end else if (acc) hv = 0;
    end
  endtask

  task automatic cyc();
    if (rand_rdy) sample_ready = 1'($urandom);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (frame_err === 1'b1) fe_seen++;
    chk("valid", 32'(sample_valid), 32'(hv));
    chk("data", 32'(sample_data), 32'(hd));
    chk("channel", 32'(sample_channel), 32'(hc));
    chk("overflow", 32'(overflow), 32'(ov));
    chk("frame_err", 32'(frame_err), 32'(fe));
  endtask

  task automatic rise_bit(input logic l, input logic d,
                          input bit pulse);
    bck = 1'b1; lrck = l; sdata = d;
    if (pulse) sample_ready = 1'b1;
    cyc();
    if (pulse) sample_ready = 1'b0;
    cyc();
    bck = 1'b0;
    cyc();
    cyc();
  endtask

  // one slot of nr rises; rise 0 is the lrck change edge
  task automatic slot(input logic l, input logic [SW-1:0] w,
                      input int nr, input int pk = -1);
    for (int k = 0; k < nr; k++) begin
      logic d;
      if (k == 0 && carry_v) d = carry_b;
      else if (k >= 2 && k <= SW + 1) d = w[SW+1-k];
      else d = 1'($urandom);
      rise_bit(l, d, k == pk);
    end
    carry_v = (nr == SW + 1);
    carry_b = w[0];
  endtask

  initial begin
    logic [SW-1:0] w5, w6, w7, w8, w9, wa, wb, wc;
    int fe0;
    logic last_l;
    w5 = SW'($urandom); w6 = SW'($urandom);
    w7 = SW'($urandom); w8 = SW'($urandom);
    w9 = SW'($urandom); wa = SW'($urandom);
    wb = SW'($urandom); wc = SW'($urandom);
    reset = 1'b1; bck = 1'b0; lrck = 1'b0;
    sdata = 1'b0; sample_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_data", 32'(sample_data), 32'h0);
    reset = 1'b0;

    sample_ready = 1'b1;
    slot(1'b1, SW'($urandom), 30);
    slot(1'b0, 24'hA5C31E, 32);
    chk("nom_left", 32'(sample_data), 32'hA5C31E);
    chk("nom_left_ch", 32'(sample_channel), 32'h0);
    slot(1'b1, 24'h5A3CE1, 32);
    chk("nom_right", 32'(sample_data), 32'h5A3CE1);
    chk("nom_right_ch", 32'(sample_channel), 32'h1);

    fe0 = fe_seen;
    slot(1'b0, SW'($urandom), 12);
    slot(1'b1, w5, 32);
    chk("short_fe_cycles", 32'(fe_seen - fe0), 32'h1);
    chk("short_next", 32'(sample_data), 32'(w5));

    fe0 = fe_seen;
    slot(1'b0, w6, 25);
    slot(1'b1, w7, 32);
    chk("exact24_fe", 32'(fe_seen - fe0), 32'h0);
    chk("exact24_next", 32'(sample_data), 32'(w7));

    sample_ready = 1'b0;
    slot(1'b0, w8, 32);
    chk("simul_hold", 32'(sample_data), 32'(w8));
    slot(1'b1, w9, 32, SW + 1);
    chk("simul_valid", 32'(sample_valid), 32'h1);
    chk("simul_data", 32'(sample_data), 32'(w9));
    chk("simul_ovf", 32'(overflow), 32'h0);
    sample_ready = 1'b1;
    cyc();
    sample_ready = 1'b0;

    slot(1'b0, wa, 32);
    slot(1'b1, wb, 32);
    chk("bp_hold", 32'(sample_data), 32'(wa));
    chk("bp_ovf", 32'(overflow), 32'h1);
    sample_ready = 1'b1;
    cyc();
    sample_ready = 1'b0;
    cyc();
    chk("bp_drained", 32'(sample_valid), 32'h0);
    chk("bp_sticky", 32'(overflow), 32'h1);

    sample_ready = 1'b1;
    slot(1'b0, SW'($urandom), 10);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_ovf", 32'(overflow), 32'h0);
    chk("rst_mid_valid", 32'(sample_valid), 32'h0);
    slot(1'b0, SW'($urandom), 30);
    chk("rst_hunt", 32'(sample_valid), 32'h0);
    slot(1'b1, wc, 32);
    chk("rst_recover", 32'(sample_data), 32'(wc));

    rand_rdy = 1;
    last_l = 1'b1;
    repeat (40) begin
      last_l = ~last_l;
      slot(last_l, SW'($urandom), $urandom_range(8, 34));
    end
    rand_rdy = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
Serial-to-parallel audio receiver: converts an I2S bit stream (bck, lrck, sdata) into parallel samples with a valid/ready handshake.
- Sits directly downstream of the delay_reg synchroniser chain, which presents bck/lrck/sdata already retimed into the clk domain.
- Feeds the sample FIFO / DSP input stage.
- Everything runs on clk; bck is treated as data and edge-detected, never used as a clock.

Parameters:
SAMPLE_WIDTH, 24, bits captured per channel slot, MSB first
SLOT_MIN, 16, minimum bck rising edges per slot; fewer means a short frame (error)
SLOT_MAX, 32, bit-counter saturation value; counter width is clog2(SLOT_MAX+1)

Ports:
clk  input  1  system clock; sole clock of the block
reset  input  1  synchronous, active-high reset
bck  input  1  synchronised I2S bit clock (level, clk domain)
lrck  input  1  synchronised word select; 0 = left, 1 = right
sdata  input  1  synchronised serial data
sample_data  output  SAMPLE_WIDTH  captured sample, MSB = first bit after the delay bit
sample_channel  output  1  channel of sample_data (lrck value during its slot)
sample_valid  output  1  sample_data/sample_channel hold a sample
sample_ready  input  1  consumer accepts when sample_valid & sample_ready
overflow  output  1  sticky: a completed sample was dropped
frame_err  output  1  one-cycle pulse: slot ended before SAMPLE_WIDTH bits or before SLOT_MIN edges

Behaviour:
Reset and edge detection:
- Reset (synchronous, active-high; dominates all else): every output is 0; state = HUNT; bit_cnt = 0; shift register = 0; bck_prev = 0; lrck_prev = 0.
- Edge detect: rise = bck & ~bck_prev, registered every clk. All stream logic advances only in cycles where rise = 1. lrck and sdata are sampled in the same cycle.

States (evaluated on rise):
- HUNT: ignore data. On lrck != lrck_prev, go to DELAY with bit_cnt = 0 and chan = lrck.
- DELAY: this edge is the I2S one-bit delay. Data is ignored; go to SHIFT; bit_cnt = 1.
- SHIFT: shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], sdata}; bit_cnt++. When this edge is bit SAMPLE_WIDTH, attempt output load (see Output load) and go to DRAIN.
- DRAIN: ignore data; bit_cnt++, saturating at SLOT_MAX.

Slot boundary:
- lrck is compared to lrck_prev on every rise, and lrck_prev updates on rise.
- A change of lrck in DELAY, SHIFT or DRAIN starts a new slot: go to DELAY, bit_cnt = 0, chan = lrck.
- If the old slot was in SHIFT or DELAY, or its bit_cnt < SLOT_MIN, pulse frame_err for one cycle. The partial word is discarded.
- A change of lrck on the very edge that completes bit SAMPLE_WIDTH does both actions: the sample loads and the new slot starts.

Output load:
- The load happens in the clk cycle N in which rise completes the sample. sample_valid is high from cycle N+1.
- Cases at load time:
  - sample_valid = 0: load sample_data and sample_channel; set valid.
  - sample_valid = 1 and sample_ready = 1 in cycle N: the old word is accepted and the new word loads. Valid stays 1; no overflow.
  - sample_valid = 1 and sample_ready = 0: the new word is dropped, the held word is unchanged, and overflow is set.
- overflow clears only on reset.
- Handshake: sample_valid falls the cycle after a valid & ready cycle (unless a load occurs in that same cycle). sample_data is stable while valid & !ready.

Other rules:
- A bck held static stalls all state and the held output; there is no timeout.
- lrck is treated as an ordinary sampled signal. Changes between bck edges take effect at the next rise.

Decomposition:
- Package i2s_rx_pkg holds:
  - state encoding constants ST_HUNT=2'd0, ST_DELAY=2'd1, ST_SHIFT=2'd2, ST_DRAIN=2'd3
  - CH_LEFT=1'b0, CH_RIGHT=1'b1
- Natural sub-module: edge_rise_det (1-bit registered rising-edge detector with synchronous reset), instantiated for bck.
- Shift register, counter, FSM and output register stay in the top.

Test Plan:
1. Reset mid-stream: assert reset for 1 cycle during SHIFT -> next cycle all outputs 0, state HUNT; no sample until the next lrck change plus SAMPLE_WIDTH+1 edges.
2. Nominal stereo, 32 bck per slot, left word 0xA5C31E, right word 0x5A3CE1, sample_ready=1 -> sample_valid pulses high once per slot; data 0xA5C31E with channel 0, then 0x5A3CE1 with channel 1. Valid is high the cycle after the 25th rise in each slot; no errors.
3. Backpressure: sample_ready=0 across two slots -> first word held stable, second dropped, overflow=1 and sticky. Raising ready then yields a single handshake of the first word.
4. Simultaneous accept and load: ready pulsed high exactly in the completion cycle N -> sample_valid stays 1, sample_data switches to the new word at N+1, overflow stays 0.
5. Short slot: lrck toggles after 10 data bits -> frame_err high for exactly one cycle, no sample_valid, and the following full 32-bit slot captures correctly.
6. Slot of exactly 24 data bits (lrck toggles on the completing edge) -> sample loaded and new slot starts in DELAY; frame_err stays 0 with SLOT_MIN=16.
